puf_challenge_sequencer: RTL and testbench
==========================================

Name: puf_challenge_sequencer

Overview:
- Control and collection stage that sits directly around puf_parallel.
- Walks a batch of 8-bit challenges and drives the PUF enable, challenge and reset for each one.
- Captures the 8-bit response on all_done, repeats each challenge NUM_EVALS times and majority-votes each bit.
- Hands one voted response per challenge downstream over a valid/ready interface.

Parameters:
- NUM_EVALS, 7: evaluations per challenge; must be odd and >=1.
- SETTLE_CYCLES, 4: cycles puf_reset is held high before each evaluation.
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for all_done before abandoning an evaluation.
- ENABLE_W, 32: width of the PUF enable bus.

Ports:
- clock  in  1  system clock.
- computer_reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a batch, honoured only in IDLE.
- first_challenge  in  8  first challenge of the batch.
- num_challenges  in  8  challenges in the batch; 0 means 256.
- enable_mask  in  ENABLE_W  value driven on puf_enable during evaluation.
- puf_enable  out  ENABLE_W  to puf_parallel enable.
- puf_challenge  out  8  to puf_parallel challenge.
- puf_reset  out  1  to puf_parallel computer_reset, active-high.
- puf_out  in  8  from puf_parallel out; asynchronous.
- puf_all_done  in  1  from puf_parallel all_done; asynchronous.
- resp_valid  out  1  voted response available.
- resp_ready  in  1  downstream accepts the response.
- resp_challenge  out  8  challenge that produced resp_data.
- resp_data  out  8  majority-voted response.
- resp_timeout  out  1  at least one evaluation of this challenge timed out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (async assert, sync deassert handled upstream):
  - state=IDLE; puf_enable=0; puf_challenge=0; puf_reset=1.
  - resp_valid=0; resp_challenge=0; resp_data=0; resp_timeout=0; busy=0.
  - All counters and sync flops cleared.
- puf_all_done passes through a 2-flop synchronizer (done_s); puf_out is sampled only after done_s=1.
- IDLE:
  - puf_reset=1, puf_enable=0.
  - start=1: latch first_challenge into cur_chal, latch num_challenges into remaining (0 loads 256), clear eval_cnt, vote counters and timeout flag, go to PRESET.
- PRESET:
  - puf_challenge=cur_chal, puf_reset=1, puf_enable=0.
  - After SETTLE_CYCLES cycles go to RUN.
- RUN:
  - puf_reset=0, puf_enable=enable_mask; wait counter increments each cycle.
  - done_s=1: go to CAPTURE.
  - Wait counter reaches TIMEOUT_CYCLES-1 with done_s still 0: set the timeout flag, add no votes, go to NEXT_EVAL.
  - If done_s and timeout occur in the same cycle, done wins.
- CAPTURE:
  - One cycle; for each bit i, vote_cnt[i] += puf_out[i].
  - Go to NEXT_EVAL.
- NEXT_EVAL:
  - puf_enable=0, puf_reset=1.
  - eval_cnt < NUM_EVALS-1: increment eval_cnt, go to PRESET.
  - Otherwise go to OUTPUT.
- OUTPUT:
  - On entry, load resp_data[i] = (vote_cnt[i] > NUM_EVALS/2), resp_challenge=cur_chal, resp_timeout=flag; assert resp_valid.
  - resp_valid and all resp_* signals stay stable until resp_valid && resp_ready.
  - On the handshake, the same cycle: deassert resp_valid, decrement remaining, increment cur_chal (wraps 255->0), clear votes, eval_cnt and flag.
  - Then remaining reaches 0: go to IDLE; otherwise go to PRESET.
  - resp_ready high before resp_valid has no effect.
- start pulses outside IDLE are ignored.
- Reset asserted mid-batch aborts immediately; the PUF is held in reset and any pending response is dropped.
- Vote counter width is clog2(NUM_EVALS+1), so counters never saturate.
- Minimum per-evaluation latency is SETTLE_CYCLES + 2 (sync) + 1 (capture) + 1 (next).

Decomposition:
- Shared package puf_pkg:
  - state enum (IDLE, PRESET, RUN, CAPTURE, NEXT_EVAL, OUTPUT);
  - CHAL_W=8, RESP_W=8 constants;
  - vote width function.
- One sub-module, puf_done_sync: the 2-flop synchronizer with async active-low clear.
- The voting logic stays inline as a generate loop of 8 counters.

Test Plan:
- Stable PUF model (done 10 cycles after enable, out=0xA5), start with first=0x10, num=1 → one response: challenge 0x10, data 0xA5, timeout=0; 7 evaluations observed.
- Noisy model returning 0xFF on 3 of 7 evaluations and 0x00 on 4 → resp_data=0x00; flip the split to 4/3 → 0xFF.
- Batch first=0xFE, num=3 with resp_ready always high → challenges 0xFE, 0xFF, 0x00 in order, then busy=0.
- puf_all_done tied 0 → after TIMEOUT_CYCLES per evaluation, resp_timeout=1 and resp_data=0x00; the FSM still advances and returns to IDLE.
- resp_ready held low 50 cycles in OUTPUT → resp_valid and data stable, no new PUF activity; accepted on the first ready cycle.
- computer_reset_n pulsed low during RUN → all outputs at reset values the same cycle; a new start after release runs a clean batch.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF challenge sequencer.
`timescale 1ns/1ps
package puf_pkg;

  localparam int CHAL_W = 8;
  localparam int RESP_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESET    = 3'd1,
    RUN       = 3'd2,
    CAPTURE   = 3'd3,
    NEXT_EVAL = 3'd4,
    OUTPUT    = 3'd5
  } state_t;

  // Bits needed to count 0..n votes without saturating.
  function automatic int vote_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/puf_done_sync.sv
// Two-flop synchronizer for the asynchronous all_done flag from the PUF.
`timescale 1ns/1ps
module puf_done_sync (
  input  logic clock,
  input  logic computer_reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic sync_p0;
  logic sync_p1;

  // Stage 0 -> stage 1: metastability filter on the raw flag
  always_ff @(posedge clock or negedge computer_reset_n) begin
    if (!computer_reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
    end
  end

  assign sync_out = sync_p1;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives puf_parallel through a batch of challenges, repeats each one
// NUM_EVALS times, majority-votes every response bit and hands one voted
// response per challenge downstream over valid/ready.
`timescale 1ns/1ps
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int NUM_EVALS      = 7,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ENABLE_W       = 32
) (
  input  logic                clock,
  input  logic                computer_reset_n,
  input  logic                start,
  input  logic [CHAL_W-1:0]   first_challenge,
  input  logic [7:0]          num_challenges,
  input  logic [ENABLE_W-1:0] enable_mask,
  output logic [ENABLE_W-1:0] puf_enable,
  output logic [CHAL_W-1:0]   puf_challenge,
  output logic                puf_reset,
  input  logic [RESP_W-1:0]   puf_out,
  input  logic                puf_all_done,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [CHAL_W-1:0]   resp_challenge,
  output logic [RESP_W-1:0]   resp_data,
  output logic                resp_timeout,
  output logic                busy
);

  localparam int VOTE_W = vote_w(NUM_EVALS);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int WT_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [VOTE_W-1:0] VOTE_HALF = VOTE_W'(NUM_EVALS / 2);
  localparam logic [VOTE_W-1:0] EVAL_LAST = VOTE_W'(NUM_EVALS - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [WT_W-1:0]   WT_LAST   = WT_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  state_t              state_nxt;
  logic                done_s;
  logic [SET_W-1:0]    settle_cnt;
  logic [WT_W-1:0]     wait_cnt;
  logic [VOTE_W-1:0]   eval_cnt;
  logic [8:0]          remaining;
  logic [CHAL_W-1:0]   cur_chal;
  logic                to_flag;
  logic [RESP_W-1:0]   voted;

  logic start_ok;
  logic settle_last;
  logic wait_last;
  logic eval_last;
  logic handshake;
  logic clear_votes;

  assign start_ok    = (state == IDLE) && start;
  assign settle_last = (settle_cnt == SET_LAST);
  assign wait_last   = (wait_cnt == WT_LAST);
  assign eval_last   = (eval_cnt == EVAL_LAST);
  assign handshake   = (state == OUTPUT) && resp_valid && resp_ready;
  assign clear_votes = start_ok || handshake;

  puf_done_sync u_done_sync (
    .clock            (clock),
    .computer_reset_n (computer_reset_n),
    .async_in         (puf_all_done),
    .sync_out         (done_s)
  );

  // State register
  always_ff @(posedge clock or negedge computer_reset_n) begin
    if (!computer_reset_n) state <= IDLE;
    else                   state <= state_nxt;
  end

  // Next-state logic; in RUN a simultaneous done and timeout resolves to done
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start) state_nxt = PRESET;
      PRESET:    if (settle_last) state_nxt = RUN;
      RUN: begin
        if (done_s)         state_nxt = CAPTURE;
        else if (wait_last) state_nxt = NEXT_EVAL;
      end
      CAPTURE:   state_nxt = NEXT_EVAL;
      NEXT_EVAL: state_nxt = eval_last ? OUTPUT : PRESET;
      OUTPUT: begin
        if (handshake) state_nxt = (remaining == 9'd1) ? IDLE : PRESET;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // PUF drive: held in reset with enables off except while evaluating
  always_comb begin
    puf_reset  = 1'b1;
    puf_enable = '0;
    busy       = (state != IDLE);
    if (state == RUN || state == CAPTURE) begin
      puf_reset  = 1'b0;
      puf_enable = enable_mask;
    end
  end

  assign puf_challenge = cur_chal;

  // Settle and timeout counters restart whenever their state is left
  always_ff @(posedge clock or negedge computer_reset_n) begin
    if (!computer_reset_n) begin
      settle_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      settle_cnt <= (state == PRESET) ? settle_cnt + SET_W'(1) : '0;
      wait_cnt   <= (state == RUN)    ? wait_cnt + WT_W'(1)    : '0;
    end
  end

  // Batch bookkeeping: current challenge, challenges left, eval index, timeout flag
  always_ff @(posedge clock or negedge computer_reset_n) begin
    if (!computer_reset_n) begin
      cur_chal  <= '0;
      remaining <= '0;
      eval_cnt  <= '0;
      to_flag   <= 1'b0;
    end else if (start_ok) begin
      cur_chal  <= first_challenge;
      remaining <= (num_challenges == 8'd0) ? 9'd256 : {1'b0, num_challenges};
      eval_cnt  <= '0;
      to_flag   <= 1'b0;
    end else if (handshake) begin
      cur_chal  <= cur_chal + CHAL_W'(1);
      remaining <= remaining - 9'd1;
      eval_cnt  <= '0;
      to_flag   <= 1'b0;
    end else begin
      if (state == RUN && !done_s && wait_last) to_flag <= 1'b1;
      if (state == NEXT_EVAL && !eval_last) eval_cnt <= eval_cnt + VOTE_W'(1);
    end
  end

  // One vote counter per response bit; counts ones seen across evaluations
  for (genvar i = 0; i < RESP_W; i++) begin : g_vote
    logic [VOTE_W-1:0] cnt;

    // Accumulate bit i on each capture, cleared per challenge
    always_ff @(posedge clock or negedge computer_reset_n) begin
      if (!computer_reset_n)    cnt <= '0;
      else if (clear_votes)     cnt <= '0;
      else if (state == CAPTURE) cnt <= cnt + VOTE_W'(puf_out[i]);
    end

    assign voted[i] = (cnt > VOTE_HALF);
  end

  // Response register: loaded on the way into OUTPUT, held until accepted
  always_ff @(posedge clock or negedge computer_reset_n) begin
    if (!computer_reset_n) begin
      resp_valid     <= 1'b0;
      resp_challenge <= '0;
      resp_data      <= '0;
      resp_timeout   <= 1'b0;
    end else if (state == NEXT_EVAL && eval_last) begin
      resp_valid     <= 1'b1;
      resp_challenge <= cur_chal;
      resp_data      <= voted;
      resp_timeout   <= to_flag;
    end else if (handshake) begin
      resp_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: behavioural PUF model, response
// scoreboard, a table of batch vectors and hand-written corner sequences.
`timescale 1ns/1ps
module tb_puf_challenge_sequencer;

  localparam int EW = 32;

  logic          clock = 1'b0;
  logic          computer_reset_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    first_challenge = 8'h00;
  logic [7:0]    num_challenges = 8'h00;
  logic [EW-1:0] enable_mask = 32'h0000_00FF;
  logic [EW-1:0] puf_enable;
  logic [7:0]    puf_challenge;
  logic          puf_reset;
  logic [7:0]    puf_out = 8'h00;
  logic          puf_all_done = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [7:0]    resp_challenge;
  logic [7:0]    resp_data;
  logic          resp_timeout;
  logic          busy;

  always #5 clock = ~clock;

  puf_challenge_sequencer #(
    .NUM_EVALS(7), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(1024), .ENABLE_W(EW)
  ) dut (
    .clock(clock), .computer_reset_n(computer_reset_n), .start(start),
    .first_challenge(first_challenge), .num_challenges(num_challenges),
    .enable_mask(enable_mask), .puf_enable(puf_enable),
    .puf_challenge(puf_challenge), .puf_reset(puf_reset), .puf_out(puf_out),
    .puf_all_done(puf_all_done), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_challenge(resp_challenge),
    .resp_data(resp_data), .resp_timeout(resp_timeout), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // PUF model: first m_hi_cnt evaluations of a batch return m_hi, the rest m_lo
  logic [7:0] m_hi = 8'hA5;
  logic [7:0] m_lo = 8'hA5;
  int         m_hi_cnt = 7;
  bit         m_dead = 1'b0;
  int         evals_seen = 0;
  int         eval_base = 0;
  int         run_cnt = 0;
  int         idx;

  always @(posedge clock) begin
    if (puf_reset) begin
      run_cnt = 0;
      puf_all_done <= 1'b0;
    end else if (puf_enable != '0 && !m_dead) begin
      if (run_cnt == 9) begin
        idx = (evals_seen - eval_base) % 7;
        puf_out <= (idx < m_hi_cnt) ? m_hi : m_lo;
        puf_all_done <= 1'b1;
        evals_seen++;
      end
      run_cnt++;
    end
  end

  // Scoreboard of expected responses, popped on every accepted response
  typedef struct {
    logic [7:0] chal;
    logic [7:0] data;
    logic       to;
  } exp_t;
  exp_t sb[$];

  exp_t got;
  always @(negedge clock) begin
    if (computer_reset_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(resp_challenge), 32'hFFFF_FFFF);
      end else begin
        got = sb.pop_front();
        check("resp_challenge", 32'(resp_challenge), 32'(got.chal));
        check("resp_data", 32'(resp_data), 32'(got.data));
        check("resp_timeout", 32'(resp_timeout), 32'(got.to));
      end
    end
  end

  task automatic push_expected(input logic [7:0] first, input int n,
                               input logic [7:0] d, input logic to);
    logic [7:0] c;
    for (int k = 0; k < n; k++) begin
      c = first + 8'(k);
      sb.push_back('{c, d, to});
    end
  endtask

  task automatic pulse_start(input logic [7:0] first, input int num);
    @(posedge clock); #1;
    first_challenge = first;
    num_challenges  = 8'(num);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int cyc = 0;
    while (busy && cyc < bound) begin
      @(negedge clock);
      cyc++;
    end
    check("batch_done_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] first;
    int         num;
    logic [7:0] hi;
    logic [7:0] lo;
    int         hi_cnt;
    bit         dead;
    logic [7:0] exp_data;
    logic       exp_to;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] cap_d, cap_c;
    int unstable, activity, n, wcyc;

    vecs[0] = '{8'h10, 1, 8'hA5, 8'hA5, 7, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{8'h20, 1, 8'hFF, 8'h00, 3, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'h30, 1, 8'hFF, 8'h00, 4, 1'b0, 8'hFF, 1'b0};
    vecs[3] = '{8'hFE, 3, 8'hA5, 8'hA5, 7, 1'b0, 8'hA5, 1'b0};
    vecs[4] = '{8'h40, 1, 8'h00, 8'h00, 0, 1'b1, 8'h00, 1'b1};

    // Reset values
    #12;
    check("rst_puf_reset", 32'(puf_reset), 32'd1);
    check("rst_puf_enable", puf_enable, 32'd0);
    check("rst_puf_challenge", 32'(puf_challenge), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_challenge", 32'(resp_challenge), 32'd0);
    check("rst_resp_timeout", 32'(resp_timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    computer_reset_n = 1'b1;

    // Table-driven batches
    for (int v = 0; v < 5; v++) begin
      m_hi = vecs[v].hi; m_lo = vecs[v].lo;
      m_hi_cnt = vecs[v].hi_cnt; m_dead = vecs[v].dead;
      eval_base = evals_seen;
      resp_ready = 1'b1;
      push_expected(vecs[v].first, vecs[v].num, vecs[v].exp_data, vecs[v].exp_to);
      pulse_start(vecs[v].first, vecs[v].num);
      wait_idle(vecs[v].dead ? 20000 : 2000);
      check("evals_observed", 32'(evals_seen - eval_base),
            vecs[v].dead ? 32'd0 : 32'(7 * vecs[v].num));
      check("sb_drained", 32'(sb.size()), 32'd0);
    end

    // Backpressure: response held for 50 cycles, stray start ignored
    m_hi = 8'h3C; m_lo = 8'h3C; m_hi_cnt = 7; m_dead = 1'b0;
    eval_base = evals_seen;
    resp_ready = 1'b0;
    push_expected(8'h50, 1, 8'h3C, 1'b0);
    pulse_start(8'h50, 1);
    wcyc = 0;
    while (!resp_valid && wcyc < 2000) begin
      @(negedge clock);
      wcyc++;
    end
    check("bp_valid_seen", 32'(resp_valid), 32'd1);
    cap_d = resp_data; cap_c = resp_challenge;
    unstable = 0; activity = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      start = (c == 10);
      first_challenge = 8'h99;
      if (resp_valid !== 1'b1 || resp_data !== cap_d || resp_challenge !== cap_c)
        unstable++;
      if (puf_reset !== 1'b1 || puf_enable !== '0) activity++;
    end
    start = 1'b0;
    check("bp_stable", 32'(unstable), 32'd0);
    check("bp_no_puf_activity", 32'(activity), 32'd0);
    check("bp_data_held", 32'(cap_d), 32'h3C);
    @(posedge clock); #1;
    resp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("bp_valid_dropped", 32'(resp_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_sb_drained", 32'(sb.size()), 32'd0);
    check("bp_evals", 32'(evals_seen - eval_base), 32'd7);

    // Reset during RUN aborts the batch at once
    eval_base = evals_seen;
    push_expected(8'h60, 2, 8'h3C, 1'b0);
    pulse_start(8'h60, 2);
    wcyc = 0;
    while (puf_reset && wcyc < 200) begin
      @(negedge clock);
      wcyc++;
    end
    check("mid_in_run", 32'(puf_reset), 32'd0);
    computer_reset_n = 1'b0;
    #1;
    check("mid_puf_reset", 32'(puf_reset), 32'd1);
    check("mid_puf_enable", puf_enable, 32'd0);
    check("mid_puf_challenge", 32'(puf_challenge), 32'd0);
    check("mid_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    sb.delete();
    repeat (3) @(negedge clock);
    computer_reset_n = 1'b1;

    // Clean batch after the abort
    m_hi = 8'h5A; m_lo = 8'h5A;
    eval_base = evals_seen;
    push_expected(8'h70, 1, 8'h5A, 1'b0);
    pulse_start(8'h70, 1);
    wait_idle(2000);
    n = evals_seen - eval_base;
    check("post_rst_evals", 32'(n), 32'd7);
    check("post_rst_sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
